// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes: four shared inverse S-boxes substitute one 32-bit lane per cycle.
// Optional macro INVSB_PARALLEL_EN: sixteen S-boxes substitute the whole state in one BUSY cycle.
module inv_sub_bytes_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // FIPS-197 inverse S-box as a flat lookup
  function automatic logic [7:0] inv_sbox(input logic [7:0] i_b);
    logic [7:0] v;
    case (i_b)
      8'h00: v = 8'h52; 8'h01: v = 8'h09; 8'h02: v = 8'h6a; 8'h03: v = 8'hd5;
      8'h04: v = 8'h30; 8'h05: v = 8'h36; 8'h06: v = 8'ha5; 8'h07: v = 8'h38;
      8'h08: v = 8'hbf; 8'h09: v = 8'h40; 8'h0a: v = 8'ha3; 8'h0b: v = 8'h9e;
      8'h0c: v = 8'h81; 8'h0d: v = 8'hf3; 8'h0e: v = 8'hd7; 8'h0f: v = 8'hfb;
      8'h10: v = 8'h7c; 8'h11: v = 8'he3; 8'h12: v = 8'h39; 8'h13: v = 8'h82;
      8'h14: v = 8'h9b; 8'h15: v = 8'h2f; 8'h16: v = 8'hff; 8'h17: v = 8'h87;
      8'h18: v = 8'h34; 8'h19: v = 8'h8e; 8'h1a: v = 8'h43; 8'h1b: v = 8'h44;
      8'h1c: v = 8'hc4; 8'h1d: v = 8'hde; 8'h1e: v = 8'he9; 8'h1f: v = 8'hcb;
      8'h20: v = 8'h54; 8'h21: v = 8'h7b; 8'h22: v = 8'h94; 8'h23: v = 8'h32;
      8'h24: v = 8'ha6; 8'h25: v = 8'hc2; 8'h26: v = 8'h23; 8'h27: v = 8'h3d;
      8'h28: v = 8'hee; 8'h29: v = 8'h4c; 8'h2a: v = 8'h95; 8'h2b: v = 8'h0b;
      8'h2c: v = 8'h42; 8'h2d: v = 8'hfa; 8'h2e: v = 8'hc3; 8'h2f: v = 8'h4e;
      8'h30: v = 8'h08; 8'h31: v = 8'h2e; 8'h32: v = 8'ha1; 8'h33: v = 8'h66;
      8'h34: v = 8'h28; 8'h35: v = 8'hd9; 8'h36: v = 8'h24; 8'h37: v = 8'hb2;
      8'h38: v = 8'h76; 8'h39: v = 8'h5b; 8'h3a: v = 8'ha2; 8'h3b: v = 8'h49;
      8'h3c: v = 8'h6d; 8'h3d: v = 8'h8b; 8'h3e: v = 8'hd1; 8'h3f: v = 8'h25;
      8'h40: v = 8'h72; 8'h41: v = 8'hf8; 8'h42: v = 8'hf6; 8'h43: v = 8'h64;
      8'h44: v = 8'h86; 8'h45: v = 8'h68; 8'h46: v = 8'h98; 8'h47: v = 8'h16;
      8'h48: v = 8'hd4; 8'h49: v = 8'ha4; 8'h4a: v = 8'h5c; 8'h4b: v = 8'hcc;
      8'h4c: v = 8'h5d; 8'h4d: v = 8'h65; 8'h4e: v = 8'hb6; 8'h4f: v = 8'h92;
      8'h50: v = 8'h6c; 8'h51: v = 8'h70; 8'h52: v = 8'h48; 8'h53: v = 8'h50;
      8'h54: v = 8'hfd; 8'h55: v = 8'hed; 8'h56: v = 8'hb9; 8'h57: v = 8'hda;
      8'h58: v = 8'h5e; 8'h59: v = 8'h15; 8'h5a: v = 8'h46; 8'h5b: v = 8'h57;
      8'h5c: v = 8'ha7; 8'h5d: v = 8'h8d; 8'h5e: v = 8'h9d; 8'h5f: v = 8'h84;
      8'h60: v = 8'h90; 8'h61: v = 8'hd8; 8'h62: v = 8'hab; 8'h63: v = 8'h00;
      8'h64: v = 8'h8c; 8'h65: v = 8'hbc; 8'h66: v = 8'hd3; 8'h67: v = 8'h0a;
      8'h68: v = 8'hf7; 8'h69: v = 8'he4; 8'h6a: v = 8'h58; 8'h6b: v = 8'h05;
      8'h6c: v = 8'hb8; 8'h6d: v = 8'hb3; 8'h6e: v = 8'h45; 8'h6f: v = 8'h06;
      8'h70: v = 8'hd0; 8'h71: v = 8'h2c; 8'h72: v = 8'h1e; 8'h73: v = 8'h8f;
      8'h74: v = 8'hca; 8'h75: v = 8'h3f; 8'h76: v = 8'h0f; 8'h77: v = 8'h02;
      8'h78: v = 8'hc1; 8'h79: v = 8'haf; 8'h7a: v = 8'hbd; 8'h7b: v = 8'h03;
      8'h7c: v = 8'h01; 8'h7d: v = 8'h13; 8'h7e: v = 8'h8a; 8'h7f: v = 8'h6b;
      8'h80: v = 8'h3a; 8'h81: v = 8'h91; 8'h82: v = 8'h11; 8'h83: v = 8'h41;
      8'h84: v = 8'h4f; 8'h85: v = 8'h67; 8'h86: v = 8'hdc; 8'h87: v = 8'hea;
      8'h88: v = 8'h97; 8'h89: v = 8'hf2; 8'h8a: v = 8'hcf; 8'h8b: v = 8'hce;
      8'h8c: v = 8'hf0; 8'h8d: v = 8'hb4; 8'h8e: v = 8'he6; 8'h8f: v = 8'h73;
      8'h90: v = 8'h96; 8'h91: v = 8'hac; 8'h92: v = 8'h74; 8'h93: v = 8'h22;
      8'h94: v = 8'he7; 8'h95: v = 8'had; 8'h96: v = 8'h35; 8'h97: v = 8'h85;
      8'h98: v = 8'he2; 8'h99: v = 8'hf9; 8'h9a: v = 8'h37; 8'h9b: v = 8'he8;
      8'h9c: v = 8'h1c; 8'h9d: v = 8'h75; 8'h9e: v = 8'hdf; 8'h9f: v = 8'h6e;
      8'ha0: v = 8'h47; 8'ha1: v = 8'hf1; 8'ha2: v = 8'h1a; 8'ha3: v = 8'h71;
      8'ha4: v = 8'h1d; 8'ha5: v = 8'h29; 8'ha6: v = 8'hc5; 8'ha7: v = 8'h89;
      8'ha8: v = 8'h6f; 8'ha9: v = 8'hb7; 8'haa: v = 8'h62; 8'hab: v = 8'h0e;
      8'hac: v = 8'haa; 8'had: v = 8'h18; 8'hae: v = 8'hbe; 8'haf: v = 8'h1b;
      8'hb0: v = 8'hfc; 8'hb1: v = 8'h56; 8'hb2: v = 8'h3e; 8'hb3: v = 8'h4b;
      8'hb4: v = 8'hc6; 8'hb5: v = 8'hd2; 8'hb6: v = 8'h79; 8'hb7: v = 8'h20;
      8'hb8: v = 8'h9a; 8'hb9: v = 8'hdb; 8'hba: v = 8'hc0; 8'hbb: v = 8'hfe;
      8'hbc: v = 8'h78; 8'hbd: v = 8'hcd; 8'hbe: v = 8'h5a; 8'hbf: v = 8'hf4;
      8'hc0: v = 8'h1f; 8'hc1: v = 8'hdd; 8'hc2: v = 8'ha8; 8'hc3: v = 8'h33;
      8'hc4: v = 8'h88; 8'hc5: v = 8'h07; 8'hc6: v = 8'hc7; 8'hc7: v = 8'h31;
      8'hc8: v = 8'hb1; 8'hc9: v = 8'h12; 8'hca: v = 8'h10; 8'hcb: v = 8'h59;
      8'hcc: v = 8'h27; 8'hcd: v = 8'h80; 8'hce: v = 8'hec; 8'hcf: v = 8'h5f;
      8'hd0: v = 8'h60; 8'hd1: v = 8'h51; 8'hd2: v = 8'h7f; 8'hd3: v = 8'ha9;
      8'hd4: v = 8'h19; 8'hd5: v = 8'hb5; 8'hd6: v = 8'h4a; 8'hd7: v = 8'h0d;
      8'hd8: v = 8'h2d; 8'hd9: v = 8'he5; 8'hda: v = 8'h7a; 8'hdb: v = 8'h9f;
      8'hdc: v = 8'h93; 8'hdd: v = 8'hc9; 8'hde: v = 8'h9c; 8'hdf: v = 8'hef;
      8'he0: v = 8'ha0; 8'he1: v = 8'he0; 8'he2: v = 8'h3b; 8'he3: v = 8'h4d;
      8'he4: v = 8'hae; 8'he5: v = 8'h2a; 8'he6: v = 8'hf5; 8'he7: v = 8'hb0;
      8'he8: v = 8'hc8; 8'he9: v = 8'heb; 8'hea: v = 8'hbb; 8'heb: v = 8'h3c;
      8'hec: v = 8'h83; 8'hed: v = 8'h53; 8'hee: v = 8'h99; 8'hef: v = 8'h61;
      8'hf0: v = 8'h17; 8'hf1: v = 8'h2b; 8'hf2: v = 8'h04; 8'hf3: v = 8'h7e;
      8'hf4: v = 8'hba; 8'hf5: v = 8'h77; 8'hf6: v = 8'hd6; 8'hf7: v = 8'h26;
      8'hf8: v = 8'he1; 8'hf9: v = 8'h69; 8'hfa: v = 8'h14; 8'hfb: v = 8'h63;
      8'hfc: v = 8'h55; 8'hfd: v = 8'h21; 8'hfe: v = 8'h0c; 8'hff: v = 8'h7d;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  logic [1:0]   r_state;
  logic [1:0]   w_state_nxt;
  logic [127:0] r_data;
  logic [127:0] w_data_nxt;
  logic [127:0] w_sub_data;
  logic         w_last;
  logic         r_in_ready;
  logic         r_out_valid;
  logic         r_busy;

`ifdef INVSB_PARALLEL_EN
  genvar g;
  for (g = 0; g < 16; g++) begin : g_sbox
    assign w_sub_data[8*g +: 8] = inv_sbox(r_data[8*g +: 8]);
  end
  assign w_last = 1'b1;
`else
  logic [1:0]  r_cnt;
  logic [31:0] w_lane_in;
  logic [31:0] w_lane_out;

  // Pick the lane addressed by the counter; lane 0 is the most significant word
  always_comb begin
    w_lane_in = 32'h0;
    case (r_cnt)
      2'd0:    w_lane_in = r_data[127:96];
      2'd1:    w_lane_in = r_data[95:64];
      2'd2:    w_lane_in = r_data[63:32];
      2'd3:    w_lane_in = r_data[31:0];
      default: w_lane_in = 32'h0;
    endcase
  end

  assign w_lane_out = {inv_sbox(w_lane_in[31:24]), inv_sbox(w_lane_in[23:16]),
                       inv_sbox(w_lane_in[15:8]),  inv_sbox(w_lane_in[7:0])};

  // Write the substituted lane back in place, other lanes untouched
  always_comb begin
    w_sub_data = r_data;
    case (r_cnt)
      2'd0:    w_sub_data[127:96] = w_lane_out;
      2'd1:    w_sub_data[95:64]  = w_lane_out;
      2'd2:    w_sub_data[63:32]  = w_lane_out;
      2'd3:    w_sub_data[31:0]   = w_lane_out;
      default: w_sub_data = r_data;
    endcase
  end

  assign w_last = (r_cnt == 2'd3);

  // Lane counter: cleared on accept, stepped while busy, wraps 3 -> 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 2'd0;
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt + 2'd1;
    end else if ((r_state == S_IDLE) && in_valid) begin
      r_cnt <= 2'd0;
    end else begin
      r_cnt <= r_cnt;
    end
  end
`endif

  // Next-state and working-register update
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nxt = S_BUSY;
          w_data_nxt  = in_data;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        w_data_nxt = w_sub_data;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_BUSY;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, data and handshake flags; flags decode the next state so they are registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_data      <= 128'h0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_data      <= w_data_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
      r_busy      <= (w_state_nxt == S_BUSY);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign out_data  = r_data;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Self-checking bench for inv_sub_bytes_seq; the reference inverse S-box is derived from
// GF(2^8) inversion plus the forward affine map, then inverted as a table.
module tb_inv_sub_bytes_seq;

`ifdef INVSB_PARALLEL_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 4;
`endif
  localparam int PERIOD = LAT + 2;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int checks;
  int errors;
  logic [7:0] ref_inv [256];

  inv_sub_bytes_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_ref();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      ref_inv[s] = x[7:0];
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = ref_inv[d[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Present d for one accept edge, scramble in_data afterwards, count cycles to out_valid.
  task automatic send_wait(input logic [127:0] d, output int lat);
    in_data = d; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_data = rand128();
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take_output();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 128'h0;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_known_vectors();
    logic [127:0] vin [3];
    logic [127:0] vexp [3];
    int lat;
    vin[0] = 128'h0;
    vexp[0] = 128'h52525252525252525252525252525252;
    vin[1] = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;
    vexp[1] = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
    vin[2] = 128'h637C_16FF_0163_7C16_FF01_637C_16FF_0163;
    vexp[2] = 128'h0001_FF7D_0900_01FF_7D09_0001_FF7D_0900;
    for (int v = 0; v < 3; v++) begin
      send_wait(vin[v], lat);
      checks++; if (lat != LAT) begin errors++; $display("FAIL known%0d_latency got %0d exp %0d", v, lat, LAT); end
      checks++; if (out_data !== vexp[v]) begin errors++; $display("FAIL known%0d_data got %h exp %h", v, out_data, vexp[v]); end
      checks++; if (out_data !== model(vin[v])) begin errors++; $display("FAIL known%0d_model got %h exp %h", v, out_data, model(vin[v])); end
      take_output();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++; $display("FAIL known%0d_release got rdy=%b vld=%b exp rdy=1 vld=0", v, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [127:0] d;
    int lat;
    for (int v = 0; v < 8; v++) begin
      d = rand128();
      send_wait(d, lat);
      checks++; if (lat != LAT) begin errors++; $display("FAIL rand%0d_latency got %0d exp %0d", v, lat, LAT); end
      checks++; if (out_data !== model(d)) begin errors++; $display("FAIL rand%0d_data got %h exp %h", v, out_data, model(d)); end
      take_output();
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] a;
    logic [127:0] b;
    int lat;
    a = rand128(); b = rand128();
    send_wait(a, lat);
    checks++; if (out_data !== model(a)) begin errors++; $display("FAIL bp_first_data got %h exp %h", out_data, model(a)); end
    for (int i = 0; i < 10; i++) begin
      in_data = rand128(); in_valid = i[0]; out_ready = 1'b0;
      @(negedge clk);
      checks++; if (out_data !== model(a)) begin errors++; $display("FAIL bp_hold%0d_data got %h exp %h", i, out_data, model(a)); end
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold%0d_flags got rdy=%b vld=%b exp rdy=0 vld=1", i, in_ready, out_valid);
      end
    end
    in_data = b; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_release got vld=%b rdy=%b busy=%b exp 0 1 0", out_valid, in_ready, busy);
    end
    @(negedge clk);
    in_valid = 1'b0; in_data = rand128();
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_next_accept got busy=%b rdy=%b exp 1 0", busy, in_ready);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat != LAT) begin errors++; $display("FAIL bp_next_latency got %0d exp %0d", lat, LAT); end
    checks++; if (out_data !== model(b)) begin errors++; $display("FAIL bp_next_data got %h exp %h", out_data, model(b)); end
    take_output();
  endtask

  task automatic test_reset_mid();
    int lat;
    in_data = rand128(); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_flags got vld=%b rdy=%b busy=%b exp 0 1 0", out_valid, in_ready, busy);
    end
    checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL midrst_data got %h exp 0", out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_nopulse%0d got %b exp 0", i, out_valid); end
    end
    send_wait(128'h0, lat);
    checks++; if (lat != LAT) begin errors++; $display("FAIL midrst_latency got %0d exp %0d", lat, LAT); end
    checks++; if (out_data !== 128'h52525252525252525252525252525252) begin
      errors++; $display("FAIL midrst_data_after got %h exp all 52", out_data);
    end
    take_output();
  endtask

  task automatic test_back_to_back();
    logic [127:0] vec [3];
    int acc [3];
    int sent;
    int got;
    int cyc;
    for (int v = 0; v < 3; v++) vec[v] = rand128();
    vec[1] = vec[0] ^ 128'h1;
    sent = 0; got = 0; cyc = 0;
    in_data = vec[0]; in_valid = 1'b1; out_ready = 1'b1;
    while (got < 3 && cyc < 100) begin
      if (in_valid && in_ready === 1'b1) begin
        acc[sent] = cyc;
        sent++;
      end
      if (out_valid === 1'b1) begin
        checks++; if (out_data !== model(vec[got])) begin
          errors++; $display("FAIL b2b_data%0d got %h exp %h", got, out_data, model(vec[got]));
        end
        got++;
      end
      @(posedge clk);
      #1;
      in_valid = (sent < 3);
      in_data = (sent < 3) ? vec[sent] : rand128();
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (got != 3 || sent != 3) begin errors++; $display("FAIL b2b_count got out=%0d acc=%0d exp 3 3", got, sent); end
    if (sent == 3) begin
      checks++; if (acc[1] - acc[0] != PERIOD) begin errors++; $display("FAIL b2b_gap01 got %0d exp %0d", acc[1] - acc[0], PERIOD); end
      checks++; if (acc[2] - acc[1] != PERIOD) begin errors++; $display("FAIL b2b_gap12 got %0d exp %0d", acc[2] - acc[1], PERIOD); end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 128'h0;
    build_ref();
    test_reset();
    test_known_vectors();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
